// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
// The line levels are kept here so the FSM and any future receiver agree on them.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Bit counter width for a data word of the given width; never narrower than one bit
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bundle between the upstream word source / parity_calc and the TX frame controller.
// The master side owns the data word and its parity; the slave side owns the serial line.
interface uart_tx_ctrl_if #(parameter int WIDTH = 8);

   logic [WIDTH-1:0] P_DATA;
   logic             DATA_VALID;
   logic             PAR_EN;
   logic             parity_bit;
   logic             TX_OUT;
   logic             busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, parity_bit,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, parity_bit,
      output TX_OUT, busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the data phase of a UART frame.
// The first shift after a load emits bit 0 without advancing the counter, so
// the counter reads k while bit k is on the line and ser_done marks the last bit.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data,
   output logic             ser_bit,
   output logic             ser_done
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             lead_q, lead_d;

   // Load a fresh word, or shift one bit out and count it (saturating at the last bit)
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      lead_d  = lead_q;
      if (load) begin
         shift_d = data;
         cnt_d   = '0;
         lead_d  = 1'b1;
      end else if (shift_en) begin
         shift_d = {1'b0, shift_q[WIDTH-1:1]};
         lead_d  = 1'b0;
         if (!lead_q && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers, cleared by the asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         lead_q  <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         lead_q  <= lead_d;
      end
   end

   assign ser_bit  = shift_q[0];
   assign ser_done = !lead_q && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit(s). One bit per clk; TX_OUT and busy are flops
// loaded with the level of the state being entered, so the start bit appears
// in the cycle right after the word is accepted.
// Optional build macro UART_TX_STOP2_EN: two stop bits instead of one.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctrl_if.slave  bus
);

   tx_state_e state_q, state_d;
   logic      tx_q, tx_d;
   logic      busy_q, busy_d;
   logic      par_q, par_d;
   logic      par_en_q, par_en_d;
   logic      load, shift_en, ser_bit, ser_done;
`ifdef UART_TX_STOP2_EN
   logic      stop_q, stop_d;
`endif

   uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .data     (bus.P_DATA),
      .ser_bit  (ser_bit),
      .ser_done (ser_done)
   );

   // Next state plus the line level and busy flag that go with the state being entered
   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      par_d    = par_q;
      par_en_d = par_en_q;
      load     = 1'b0;
      shift_en = 1'b0;
`ifdef UART_TX_STOP2_EN
      stop_d   = stop_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d   = IDLE_LVL;
            busy_d = 1'b0;
            if (bus.DATA_VALID) begin
               load     = 1'b1;
               par_en_d = bus.PAR_EN;
               state_d  = START;
               tx_d     = START_LVL;
               busy_d   = 1'b1;
            end
         end
         START: begin
            par_d    = bus.parity_bit;
            shift_en = 1'b1;
            tx_d     = ser_bit;
            state_d  = DATA;
         end
         DATA: begin
            if (!ser_done) begin
               shift_en = 1'b1;
               tx_d     = ser_bit;
            end else if (par_en_q) begin
               state_d = PARITY;
               tx_d    = par_q;
            end else begin
               state_d = STOP;
               tx_d    = STOP_LVL;
            end
         end
         PARITY: begin
            state_d = STOP;
            tx_d    = STOP_LVL;
         end
         STOP: begin
`ifdef UART_TX_STOP2_EN
            if (!stop_q) begin
               stop_d = 1'b1;
               tx_d   = STOP_LVL;
            end else begin
               stop_d  = 1'b0;
               state_d = IDLE;
               tx_d    = IDLE_LVL;
               busy_d  = 1'b0;
            end
`else
            state_d = IDLE;
            tx_d    = IDLE_LVL;
            busy_d  = 1'b0;
`endif
         end
         default: begin
            state_d = IDLE;
            tx_d    = IDLE_LVL;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM and output registers; reset aborts any frame and parks the line high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tx_q     <= IDLE_LVL;
         busy_q   <= 1'b0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         par_q    <= par_d;
         par_en_q <= par_en_d;
      end
   end

`ifdef UART_TX_STOP2_EN
   // Counts the first of the two stop bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stop_q <= 1'b0;
      end else begin
         stop_q <= stop_d;
      end
   end
`endif

   assign bus.TX_OUT = tx_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized traffic,
// compared cycle by cycle against a queue-based frame model.
// Honours UART_TX_STOP2_EN for the expected number of stop bits.
module tb_uart_tx_ctrl;

   localparam int WIDTH = 8;
`ifdef UART_TX_STOP2_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif

   // Expected line sequences as logged while busy, first bit in the MSB position
   localparam logic [31:0] A5P_BITS  = (NSTOP == 2) ? 32'h52B : 32'h295;
   localparam logic [31:0] A5N_BITS  = (NSTOP == 2) ? 32'h297 : 32'h14B;
   localparam logic [31:0] H3C_BITS  = (NSTOP == 2) ? 32'h0F3 : 32'h079;
   localparam logic [31:0] H55P_BITS = (NSTOP == 2) ? 32'h553 : 32'h2A9;

   logic        clk;
   logic        rst;
   logic        par_typ;
   int          errors;
   int          checks;
   logic        exp_q[$];
   logic        exp_tx;
   logic        exp_busy;
   logic        log_en;
   logic [31:0] log_val;
   int          log_len;

   uart_tx_ctrl_if #(.WIDTH(WIDTH)) bus ();

   uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for parity_calc: one register stage from P_DATA and PAR_TYP to parity_bit
   always @(posedge clk or posedge rst) begin
      if (rst) bus.parity_bit <= 1'b0;
      else     bus.parity_bit <= (^bus.P_DATA) ^ par_typ;
   end

   // Hard stop in case something blocks the main sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Frame model: an accepted word becomes a list of line levels consumed one per clock
   task automatic modelEdge(input logic dv, input logic [WIDTH-1:0] data, input logic pen, input logic ptyp);
      if (!exp_busy) begin
         if (dv) begin
            exp_q.push_back(1'b0);
            for (int i = 0; i < WIDTH; i++) exp_q.push_back(data[i]);
            if (pen) exp_q.push_back(1'(($countones(data) + int'(ptyp)) % 2));
            for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
            exp_tx   = exp_q.pop_front();
            exp_busy = 1'b1;
         end else begin
            exp_tx = 1'b1;
         end
      end else if (exp_q.size() > 0) begin
         exp_tx = exp_q.pop_front();
      end else begin
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
      end
   endtask

   task automatic modelReset();
      exp_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
   endtask

   task automatic applyStimulus(input logic dv, input logic [WIDTH-1:0] data, input logic pen);
      @(negedge clk);
      bus.DATA_VALID = dv;
      bus.P_DATA     = data;
      bus.PAR_EN     = pen;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after it
   task automatic clockCycle(input logic dv, input logic [WIDTH-1:0] data, input logic pen, input string tag);
      applyStimulus(dv, data, pen);
      @(posedge clk);
      modelEdge(dv, data, pen, par_typ);
      #1;
      checkOutput({tag, "_tx"}, 32'(bus.TX_OUT), 32'(exp_tx));
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
      if (log_en && bus.busy) begin
         log_val = {log_val[30:0], bus.TX_OUT};
         log_len++;
      end
   endtask

   task automatic drainFrame(input string tag);
      int n = 0;
      while (exp_busy && n < 40) begin
         clockCycle(1'b0, '0, 1'b0, tag);
         n++;
      end
   endtask

   task automatic directedFrame(input logic [WIDTH-1:0] data, input logic pen, input logic [31:0] exp_bits, input string tag);
      log_val = '0;
      log_len = 0;
      log_en  = 1'b1;
      clockCycle(1'b1, data, pen, tag);
      drainFrame(tag);
      log_en = 1'b0;
      checkOutput({tag, "_bits"}, log_val, exp_bits);
      checkOutput({tag, "_len"}, 32'(log_len), 32'(2 + WIDTH + int'(pen) + NSTOP - 1));
   endtask

   initial begin
      int busy_lows;
      int flen;
      errors         = 0;
      checks         = 0;
      log_en         = 1'b0;
      log_val        = '0;
      log_len        = 0;
      par_typ        = 1'b0;
      bus.DATA_VALID = 1'b0;
      bus.P_DATA     = '0;
      bus.PAR_EN     = 1'b0;
      rst            = 1'b1;
      modelReset();
      #1;
      checkOutput("reset_tx", 32'(bus.TX_OUT), 32'(1));
      checkOutput("reset_busy", 32'(bus.busy), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      repeat (10) clockCycle(1'b0, '0, 1'b0, "idle");

      directedFrame(8'hA5, 1'b1, A5P_BITS, "a5_par");
      directedFrame(8'hA5, 1'b0, A5N_BITS, "a5_nopar");

      // Word offered during the data phase must be dropped
      log_val = '0;
      log_len = 0;
      log_en  = 1'b1;
      clockCycle(1'b1, 8'h3C, 1'b0, "ign");
      repeat (3) clockCycle(1'b0, 8'h3C, 1'b0, "ign");
      clockCycle(1'b1, 8'hFF, 1'b1, "ign");
      drainFrame("ign");
      log_en = 1'b0;
      checkOutput("ign_bits", log_val, H3C_BITS);
      clockCycle(1'b0, '0, 1'b0, "ign_after");

      // DATA_VALID held: back-to-back frames with one idle bit between
      flen      = 1 + WIDTH + NSTOP;
      busy_lows = 0;
      for (int i = 0; i < 2 * flen + 1; i++) begin
         clockCycle(1'(i < flen + 2), (i == 0) ? 8'h01 : 8'h80, 1'b0, "held");
         if (!bus.busy) busy_lows++;
      end
      checkOutput("held_gap", 32'(busy_lows), 32'(1));
      drainFrame("held_tail");

      // Reset in the 4th data bit aborts the frame at once
      clockCycle(1'b1, 8'hF0, 1'b1, "abort");
      repeat (4) clockCycle(1'b0, 8'hF0, 1'b1, "abort");
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_tx", 32'(bus.TX_OUT), 32'(1));
      checkOutput("abort_busy", 32'(bus.busy), 32'(0));
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      directedFrame(8'h55, 1'b1, H55P_BITS, "after_rst");

      // Randomized traffic with both light and heavy DATA_VALID loading
      for (int i = 0; i < 400; i++) begin
         logic dv;
         if (i % 50 == 0) par_typ = 1'($urandom_range(0, 1));
         if (((i / 100) % 2) == 1) dv = 1'($urandom_range(0, 9) < 7);
         else                      dv = 1'($urandom_range(0, 9) < 2);
         clockCycle(dv, WIDTH'($urandom), 1'($urandom_range(0, 1)), "rand");
      end
      drainFrame("final");
      clockCycle(1'b0, '0, 1'b0, "final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
